// File: rtl/fifo_rd_arb.sv
// fifo_rd_arb
// Round-robin read arbiter sitting on the read side of a show-ahead FIFO.
// A winning requester receives up to BURST words per grant. After every
// burst there is exactly one IDLE cycle before the next grant is issued.
//
// Parameters:
//   DW    - data width
//   NR    - number of requesters (2..8)
//   BURST - maximum words per grant (1..15)
//
// Ports:
//   I_RD_CLK   in   1   read-domain clock
//   I_RD_RST   in   1   asynchronous active-high reset
//   I_RD_EMPTY in   1   FIFO empty flag
//   I_RD_DATA  in   DW  FIFO head word (show-ahead)
//   O_RD_EN    out  1   FIFO pop strobe (combinational)
//   I_REQ      in   NR  per-requester read request (level)
//   I_RDY      in   NR  per-requester ready (backpressure)
//   O_GNT      out  NR  one-hot grant (registered)
//   O_DATA     out  DW  delivered word (registered)
//   O_VALID    out  NR  one-hot data-valid (registered)
//   O_BUSY     out  1   high while a burst is in progress
module fifo_rd_arb #(
    parameter int DW    = 8,
    parameter int NR    = 4,
    parameter int BURST = 4
) (
    input  logic          I_RD_CLK,
    input  logic          I_RD_RST,
    input  logic          I_RD_EMPTY,
    input  logic [DW-1:0] I_RD_DATA,
    output logic          O_RD_EN,
    input  logic [NR-1:0] I_REQ,
    input  logic [NR-1:0] I_RDY,
    output logic [NR-1:0] O_GNT,
    output logic [DW-1:0] O_DATA,
    output logic [NR-1:0] O_VALID,
    output logic          O_BUSY
);

    localparam int GW = $clog2(NR);
    localparam int CW = $clog2(BURST + 1);
    localparam logic [GW-1:0] LAST_IDX = GW'(NR - 1);
    localparam logic [CW-1:0] BEAT_MAX = CW'(BURST);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    state_t        r_state;
    logic [GW-1:0] r_gidx;
    logic [CW-1:0] r_beat;
    logic [GW-1:0] r_ptr;
    logic [NR-1:0] r_gnt;
    logic [DW-1:0] r_data;
    logic [NR-1:0] r_valid;

    logic          w_win_found;
    logic [GW-1:0] w_win_idx;
    logic [GW-1:0] w_k;
    logic [NR-1:0] w_win_1h;
    logic          w_pop;
    logic [CW-1:0] w_beat_inc;
    logic [GW-1:0] w_nxt_ptr;
    logic          w_g_req;
    logic          w_g_rdy;

    // Search upward from the priority pointer, wrapping modulo NR;
    // the first requester found wins.
    always_comb begin
        w_win_found = 1'b0;
        w_win_idx   = '0;
        w_k         = '0;
        for (int unsigned i = 0; i < NR; i++) begin
            if (!w_win_found) begin
                w_k = GW'((32'(r_ptr) + i) % NR);
                if (I_REQ[w_k]) begin
                    w_win_found = 1'b1;
                    w_win_idx   = w_k;
                end
            end
        end
    end

    assign w_win_1h   = {{(NR-1){1'b0}}, 1'b1} << w_win_idx;
    assign w_g_req    = I_REQ[r_gidx];
    assign w_g_rdy    = I_RDY[r_gidx];
    assign w_beat_inc = r_beat + 1'b1;
    assign w_nxt_ptr  = (r_gidx == LAST_IDX) ? '0 : r_gidx + 1'b1;

    // Reset gating keeps the strobe low for the whole time reset is held.
    assign w_pop = (r_state == ST_BURST) && w_g_req && w_g_rdy &&
                   !I_RD_EMPTY && !I_RD_RST;

    assign O_RD_EN = w_pop;
    assign O_GNT   = r_gnt;
    assign O_DATA  = r_data;
    assign O_VALID = r_valid;
    assign O_BUSY  = (r_state == ST_BURST);

    always_ff @(posedge I_RD_CLK or posedge I_RD_RST) begin
        if (I_RD_RST) begin
            r_state <= ST_IDLE;
            r_gidx  <= '0;
            r_beat  <= '0;
            r_ptr   <= '0;
            r_gnt   <= '0;
            r_data  <= '0;
            r_valid <= '0;
        end else begin
            r_valid <= '0;
            if (r_state == ST_IDLE) begin
                r_gnt <= '0;
                if (w_win_found && !I_RD_EMPTY) begin
                    r_state <= ST_BURST;
                    r_gidx  <= w_win_idx;
                    r_gnt   <= w_win_1h;
                    r_beat  <= '0;
                end
            end else begin
                // Request drop or empty ends the burst without a pop;
                // a ready-low cycle simply stalls in place.
                if (!w_g_req || I_RD_EMPTY) begin
                    r_state <= ST_IDLE;
                    r_gnt   <= '0;
                    r_ptr   <= w_nxt_ptr;
                end else if (w_pop) begin
                    r_data  <= I_RD_DATA;
                    r_valid <= r_gnt;
                    r_beat  <= w_beat_inc;
                    if (w_beat_inc == BEAT_MAX) begin
                        r_state <= ST_IDLE;
                        r_gnt   <= '0;
                        r_ptr   <= w_nxt_ptr;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_fifo_rd_arb.sv
module tb_fifo_rd_arb;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rd_empty;
    logic [7:0] rd_data;
    logic       rd_en;
    logic [3:0] req = '0;
    logic [3:0] rdy = '0;
    logic [3:0] gnt;
    logic [7:0] odata;
    logic [3:0] ovalid;
    logic       busy;

    int unsigned n_chk  = 0;
    int unsigned n_pass = 0;
    int unsigned n_fail = 0;

    // Behavioural show-ahead FIFO
    logic [7:0] mem [256];
    logic [7:0] rd_ptr = '0;
    logic [7:0] wr_ptr = '0;

    assign rd_empty = (rd_ptr == wr_ptr);
    assign rd_data  = mem[rd_ptr];

    always @(posedge clk) begin
        if (rd_en) rd_ptr <= rd_ptr + 8'd1;
    end

    always #5 clk = ~clk;

    fifo_rd_arb #(.DW(8), .NR(4), .BURST(4)) dut (
        .I_RD_CLK   (clk),
        .I_RD_RST   (rst),
        .I_RD_EMPTY (rd_empty),
        .I_RD_DATA  (rd_data),
        .O_RD_EN    (rd_en),
        .I_REQ      (req),
        .I_RDY      (rdy),
        .O_GNT      (gnt),
        .O_DATA     (odata),
        .O_VALID    (ovalid),
        .O_BUSY     (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] d);
        mem[wr_ptr] = d;
        wr_ptr = wr_ptr + 8'd1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Entered at a negedge with the arbiter idle: grant cycle, nb beats, release.
    task automatic burst(input string tag, input logic [3:0] g, input int unsigned nb,
                         input logic [7:0] d0);
        @(negedge clk);
        chk({tag, ".gnt"}, 32'(gnt), 32'(g));
        chk({tag, ".busy"}, 32'(busy), 32'd1);
        chk({tag, ".v0"}, 32'(ovalid), 32'd0);
        for (int unsigned i = 0; i < nb; i++) begin
            @(negedge clk);
            chk({tag, ".valid"}, 32'(ovalid), 32'(g));
            chk({tag, ".data"}, 32'(odata), 32'(8'(d0 + 8'(i))));
        end
        chk({tag, ".rel_gnt"}, 32'(gnt), 32'd0);
        chk({tag, ".rel_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        @(negedge clk);
        #1;
        chk("rst.gnt", 32'(gnt), 32'd0);
        chk("rst.valid", 32'(ovalid), 32'd0);
        chk("rst.data", 32'(odata), 32'd0);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.rden", 32'(rd_en), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Single requester, two bursts with one bubble
        req = 4'b0001;
        rdy = 4'b1111;
        for (int unsigned i = 0; i < 8; i++) push(8'(8'h10 + i));
        burst("single1", 4'b0001, 4, 8'h10);
        burst("single2", 4'b0001, 4, 8'h14);
        @(negedge clk);
        chk("single.empty_gnt", 32'(gnt), 32'd0);
        chk("single.empty_rden", 32'(rd_en), 32'd0);

        // Round-robin with all requesting
        req = '0;
        do_reset();
        req = 4'b1111;
        for (int unsigned i = 0; i < 20; i++) push(8'(8'h40 + i));
        burst("rr0", 4'b0001, 4, 8'h40);
        burst("rr1", 4'b0010, 4, 8'h44);
        burst("rr2", 4'b0100, 4, 8'h48);
        burst("rr3", 4'b1000, 4, 8'h4C);
        burst("rr4", 4'b0001, 4, 8'h50);

        // Empty mid-burst
        req = '0;
        do_reset();
        req = 4'b0100;
        push(8'h80);
        push(8'h81);
        @(negedge clk);
        chk("empty.gnt", 32'(gnt), 32'b0100);
        @(negedge clk);
        chk("empty.v1", 32'(ovalid), 32'b0100);
        chk("empty.d1", 32'(odata), 32'h80);
        @(negedge clk);
        chk("empty.v2", 32'(ovalid), 32'b0100);
        chk("empty.d2", 32'(odata), 32'h81);
        chk("empty.flag", 32'(rd_empty), 32'd1);
        chk("empty.no_pop", 32'(rd_en), 32'd0);
        @(negedge clk);
        chk("empty.rel_gnt", 32'(gnt), 32'd0);
        chk("empty.rel_busy", 32'(busy), 32'd0);
        chk("empty.rel_valid", 32'(ovalid), 32'd0);
        req = 4'b1111;
        for (int unsigned i = 0; i < 4; i++) push(8'(8'h90 + i));
        burst("empty.ptr3", 4'b1000, 4, 8'h90);

        // Backpressure on requester 1
        req = '0;
        do_reset();
        req = 4'b0010;
        for (int unsigned i = 0; i < 4; i++) push(8'(8'hA0 + i));
        @(negedge clk);
        chk("bp.gnt", 32'(gnt), 32'b0010);
        @(negedge clk);
        chk("bp.v0", 32'(ovalid), 32'b0010);
        chk("bp.d0", 32'(odata), 32'hA0);
        rdy = 4'b1101;
        #1;
        chk("bp.stall_rden", 32'(rd_en), 32'd0);
        for (int unsigned i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp.stall_valid", 32'(ovalid), 32'd0);
            chk("bp.stall_hold", 32'(odata), 32'hA0);
            chk("bp.stall_busy", 32'(busy), 32'd1);
            chk("bp.stall_rden2", 32'(rd_en), 32'd0);
        end
        rdy = 4'b1111;
        #1;
        chk("bp.resume_rden", 32'(rd_en), 32'd1);
        for (int unsigned i = 1; i < 4; i++) begin
            @(negedge clk);
            chk("bp.valid", 32'(ovalid), 32'b0010);
            chk("bp.data", 32'(odata), 32'(8'(8'hA0 + 8'(i))));
        end
        chk("bp.rel_gnt", 32'(gnt), 32'd0);

        // Request drop after one beat, then reset mid-burst
        req = '0;
        do_reset();
        req = 4'b0100;
        for (int unsigned i = 0; i < 4; i++) push(8'(8'hC0 + i));
        @(negedge clk);
        chk("drop.gnt", 32'(gnt), 32'b0100);
        @(negedge clk);
        chk("drop.v0", 32'(ovalid), 32'b0100);
        chk("drop.d0", 32'(odata), 32'hC0);
        req = 4'b0000;
        #1;
        chk("drop.no_pop", 32'(rd_en), 32'd0);
        @(negedge clk);
        chk("drop.rel_gnt", 32'(gnt), 32'd0);
        chk("drop.rel_busy", 32'(busy), 32'd0);
        chk("drop.rel_valid", 32'(ovalid), 32'd0);
        chk("drop.hold", 32'(odata), 32'hC0);
        req = 4'b1111;
        @(negedge clk);
        chk("drop.ptr3", 32'(gnt), 32'b1000);
        @(negedge clk);
        chk("mrst.d1", 32'(odata), 32'hC1);
        @(negedge clk);
        chk("mrst.d2", 32'(odata), 32'hC2);
        chk("mrst.v2", 32'(ovalid), 32'b1000);
        rst = 1'b1;
        #1;
        chk("mrst.gnt", 32'(gnt), 32'd0);
        chk("mrst.valid", 32'(ovalid), 32'd0);
        chk("mrst.data", 32'(odata), 32'd0);
        chk("mrst.busy", 32'(busy), 32'd0);
        chk("mrst.rden", 32'(rd_en), 32'd0);
        @(negedge clk);
        chk("mrst.rden_held", 32'(rd_en), 32'd0);
        chk("mrst.no_pop", 32'(rd_data), 32'hC3);
        rst = 1'b0;
        @(negedge clk);
        chk("mrst.first_gnt", 32'(gnt), 32'b0001);
        @(negedge clk);
        chk("mrst.v3", 32'(ovalid), 32'b0001);
        chk("mrst.d3", 32'(odata), 32'hC3);
        @(negedge clk);
        chk("mrst.rel_gnt", 32'(gnt), 32'd0);
        chk("mrst.rel_busy", 32'(busy), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
